// File: rtl/button_pkg.sv
// Shared types and constant helpers for front-panel button decoding.
package button_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    WAIT2,
    PRESS2,
    LONG_HOLD
  } btn_state_t;

  function automatic int unsigned ms_to_cycles(input int unsigned freq_mhz,
                                               input int unsigned ms);
    return freq_mhz * 1000 * ms;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ms_timer.sv
// Millisecond timer: a cycle prescaler feeding a ms counter, both cleared by clr.
module ms_timer #(
  parameter int unsigned MS_CYC = 25000,
  parameter int unsigned CNT_W  = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  output logic [CNT_W-1:0] ms_cnt,
  output logic             ms_tick
);

  localparam int unsigned PreW = (MS_CYC > 1) ? $clog2(MS_CYC) : 1;

  logic [PreW-1:0]  presc_q;
  logic [CNT_W-1:0] ms_cnt_q;

  // High on the last cycle of each millisecond, i.e. the cycle before the wrap.
  assign ms_tick = (presc_q == PreW'(MS_CYC - 1));
  assign ms_cnt  = ms_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q  <= '0;
      ms_cnt_q <= '0;
    end else if (clr) begin
      presc_q  <= '0;
      ms_cnt_q <= '0;
    end else if (ms_tick) begin
      presc_q  <= '0;
      ms_cnt_q <= ms_cnt_q + 1'b1;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

endmodule

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into press/release/short/long/double pulses.
// Define BTN_AUTOREPEAT_EN to enable o_repeat pulses while in a long hold.
module button_event_decoder
  import button_pkg::*;
#(
  parameter int unsigned FREQ      = 25,
  parameter int unsigned LONG_MS   = 1000,
  parameter int unsigned DCLICK_MS = 300,
  parameter int unsigned REPEAT_MS = 200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_press,
  output logic o_release,
  output logic o_short,
  output logic o_long,
  output logic o_double,
  output logic o_held,
  output logic o_repeat
);

  localparam int unsigned MsCyc = ms_to_cycles(FREQ, 1);
  localparam int unsigned CntW  = $clog2(max3(LONG_MS, DCLICK_MS, REPEAT_MS) + 1);

  btn_state_t      state_q, state_d;
  logic            btn_q;
  logic            rise, fall;
  logic            timer_clr;
  logic [CntW-1:0] ms_cnt;
  logic            ms_tick;
  logic            long_due, dclick_due;

  logic press_d, release_d, short_d, long_d, double_d, held_d;
  logic press_q, release_q, short_q, long_q, double_q, held_q;

  assign rise = i_btn & ~btn_q;
  assign fall = ~i_btn & btn_q;

  // A threshold is due on the last cycle of its final millisecond, so the
  // registered pulse lands exactly T*MsCyc cycles after the entering pulse.
  assign long_due   = ms_tick && (ms_cnt == CntW'(LONG_MS - 1));
  assign dclick_due = ms_tick && (ms_cnt == CntW'(DCLICK_MS - 1));

  ms_timer #(
    .MS_CYC (MsCyc),
    .CNT_W  (CntW)
  ) u_ms_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (timer_clr),
    .ms_cnt  (ms_cnt),
    .ms_tick (ms_tick)
  );

`ifdef BTN_AUTOREPEAT_EN
  logic repeat_due, repeat_d, repeat_q, restart;
  assign repeat_due = ms_tick && (ms_cnt == CntW'(REPEAT_MS - 1));
`endif

  always_comb begin
    state_d   = state_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    short_d   = 1'b0;
    long_d    = 1'b0;
    double_d  = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
    repeat_d  = 1'b0;
    restart   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = PRESS1;
          press_d = 1'b1;
        end
      end
      PRESS1: begin
        if (fall) begin
          state_d   = WAIT2;
          release_d = 1'b1;
        end else if (long_due && i_btn) begin
          state_d = LONG_HOLD;
          long_d  = 1'b1;
        end
      end
      WAIT2: begin
        if (rise) begin
          state_d = PRESS2;
          press_d = 1'b1;
        end else if (dclick_due && !i_btn) begin
          state_d = IDLE;
          short_d = 1'b1;
        end
      end
      PRESS2: begin
        if (fall) begin
          state_d   = IDLE;
          release_d = 1'b1;
          double_d  = 1'b1;
        end else if (long_due && i_btn) begin
          state_d = LONG_HOLD;
          long_d  = 1'b1;
        end
      end
      LONG_HOLD: begin
        if (fall) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end
`ifdef BTN_AUTOREPEAT_EN
        else if (repeat_due && i_btn) begin
          repeat_d = 1'b1;
          restart  = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    held_d = (state_d == PRESS1) || (state_d == PRESS2) || (state_d == LONG_HOLD);
  end

  // Idle states hold the timer at zero so ms_cnt can never wrap.
`ifdef BTN_AUTOREPEAT_EN
  assign timer_clr = (state_d != state_q) || (state_q == IDLE) || restart;
`else
  assign timer_clr = (state_d != state_q) || (state_q == IDLE) || (state_q == LONG_HOLD);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      btn_q     <= 1'b1;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      double_q  <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      btn_q     <= i_btn;
      press_q   <= press_d;
      release_q <= release_d;
      short_q   <= short_d;
      long_q    <= long_d;
      double_q  <= double_d;
      held_q    <= held_d;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      repeat_q <= 1'b0;
    end else begin
      repeat_q <= repeat_d;
    end
  end
  assign o_repeat = repeat_q;
`else
  assign o_repeat = 1'b0;
`endif

  assign o_press   = press_q;
  assign o_release = release_q;
  assign o_short   = short_q;
  assign o_long    = long_q;
  assign o_double  = double_q;
  assign o_held    = held_q;

endmodule

// File: doc/button_event_decoder.md
Name: button_event_decoder

Overview:
- Consumes the debounced, registered button level from the upstream debounce stage (same clk domain).
- Classifies activity into single-cycle event pulses: press, release, short click, long press, double click.
- Provides a held level for UI/control logic (mode switching, menu stepping) on PTP board front panels.
- Timing is in milliseconds, derived from a cycle prescaler.

Parameters:
- FREQ, 25, clk frequency in MHz (integer ≥1); MS_CYC = FREQ*1000 cycles per ms.
- LONG_MS, 1000, hold time for a long press, ms (≥1).
- DCLICK_MS, 300, maximum gap from first release to second press for a double click, ms (≥1).
- REPEAT_MS, 200, auto-repeat period, ms (≥1); used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- i_btn  in  1  debounced button level, 1 = pressed, synchronous to clk.
- o_press  out  1  1-cycle pulse on each accepted press.
- o_release  out  1  1-cycle pulse on each accepted release.
- o_short  out  1  1-cycle pulse when a single short click is confirmed.
- o_long  out  1  1-cycle pulse when a hold reaches LONG_MS.
- o_double  out  1  1-cycle pulse on release of the second click of a double click.
- o_held  out  1  level, 1 while the FSM is in a pressed state.
- o_repeat  out  1  1-cycle auto-repeat pulse (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0):
  - all outputs 0, FSM in IDLE, timer cleared.
  - btn_q (the i_btn delay register) is set to 1, so a button already held at reset release produces no press. It must be released and pressed again.
- Edge detection: rise = i_btn & ~btn_q; fall = ~i_btn & btn_q. All outputs are registered, so each pulse appears the cycle after the detecting cycle.
- Timer:
  - prescaler counts 0..MS_CYC-1; ms_cnt increments on each wrap.
  - Both are cleared on every FSM transition.
  - "T ms elapsed" means exactly T*MS_CYC cycles after the transition cycle.
- FSM states: IDLE, PRESS1, WAIT2, PRESS2, LONG_HOLD.
  - IDLE: rise -> PRESS1, o_press. A fall in IDLE is ignored (no o_release).
  - PRESS1:
    - fall -> WAIT2, o_release.
    - LONG_MS elapsed with i_btn=1 -> LONG_HOLD, o_long.
  - WAIT2:
    - rise -> PRESS2, o_press.
    - DCLICK_MS elapsed with i_btn=0 -> IDLE, o_short.
  - PRESS2:
    - fall -> IDLE, o_release and o_double in the same cycle.
    - LONG_MS elapsed -> LONG_HOLD, o_long only. The first click is discarded: no o_short, no o_double.
  - LONG_HOLD: fall -> IDLE, o_release. No o_short.
- Latencies:
  - o_long is asserted exactly LONG_MS*MS_CYC cycles after the o_press that entered PRESS1/PRESS2.
  - o_short is asserted exactly DCLICK_MS*MS_CYC cycles after the o_release that entered WAIT2.
- Simultaneous events: an edge and a timeout in the same cycle resolve in favour of the edge. The timeout is only taken when i_btn still holds the level of the current state.
- o_held = 1 in PRESS1, PRESS2, LONG_HOLD.
- Widths:
  - prescaler $clog2(MS_CYC).
  - ms_cnt $clog2(max(LONG_MS,DCLICK_MS,REPEAT_MS)+1).
  - ms_cnt never wraps, because every state exits or restarts the timer at its threshold.
- Reset mid-operation: immediate return to IDLE, no pending pulse is emitted after reset release.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- Defined:
  - in LONG_HOLD the timer restarts every REPEAT_MS.
  - o_repeat pulses each time REPEAT_MS elapses while i_btn=1.
  - first o_repeat is at REPEAT_MS*MS_CYC cycles after o_long.
  - a fall on the expiry cycle suppresses that pulse.
- Undefined: the port is still present, o_repeat is tied 0, and no repeat logic is synthesised.

Decomposition:
- Package button_pkg:
  - enum btn_state_t {IDLE, PRESS1, WAIT2, PRESS2, LONG_HOLD}.
  - function ms_to_cycles(freq_mhz, ms).
  - function max3 for width computation.
- Sub-module ms_timer:
  - inputs clk, rst_n, clr.
  - parameters MS_CYC, CNT_W.
  - output ms_cnt.
  - reused by other timed UI blocks.

Test Plan (FREQ=1, LONG_MS=10, DCLICK_MS=4, REPEAT_MS=3):
1. Press 2000 cycles, release -> o_press, o_release, then o_short exactly 4000 cycles after o_release; o_long and o_double stay 0.
2. Press 2000, release 1000, press 2000, release -> two o_press pulses, o_double coincident with the second o_release; no o_short.
3. Hold 15000 cycles -> o_long exactly 10000 cycles after o_press, o_held=1 throughout; on release o_release only, no o_short.
4. i_btn falls on the exact cycle the 10000-cycle threshold expires -> o_release, FSM to WAIT2, o_long never pulses.
5. Assert rst_n=0 mid-PRESS1 with i_btn=1, release reset with i_btn still 1 -> no outputs; then i_btn 0 -> 1 gives o_press.
6. BTN_AUTOREPEAT_EN defined, hold 19000 cycles -> o_repeat at 13000, 16000, 19000 cycles after o_press. Without the macro, o_repeat stays 0.
